wordline_sequencer: RTL

Parametrised, registered one-hot wordline generator that decodes an ADDR_W-bit address into a 2^ADDR_W-bit wordline and can step through a multi-word burst on its own. It sits between the cache/register-array controller and the storage array. A single start pulse drives a complete block fill or read-out, one wordline per cycle, with stall support and optional wrap-around within an aligned block.

---
 rtl/wordline_sequencer.sv | 94 +++++++++
 1 files changed

// File: rtl/wordline_sequencer.sv
// Registered one-hot wordline generator that walks a burst of addresses
// from a single start pulse, with stall, linear or block-wrap stepping.
module wordline_sequencer #(
   parameter int ADDR_W  = 6,
   parameter int BURST_W = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [ADDR_W-1:0]       addr_in,
   input  logic [BURST_W-1:0]      burst_len,
   input  logic                    wrap_en,
   input  logic                    stall,
   output logic [(1<<ADDR_W)-1:0]  wordline,
   output logic                    wl_valid,
   output logic                    wl_last,
   output logic [ADDR_W-1:0]       cur_addr,
   output logic                    busy
);

   localparam int WL = 1 << ADDR_W;
   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_BURST = 1'b1;
   localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'((1 << BURST_W) - 1);

   logic [0:0]         r_state;
   logic [ADDR_W-1:0]  r_cur_addr;
   logic [BURST_W-1:0] r_remaining;
   logic               r_mode;
   logic [WL-1:0]      r_wordline;

   logic [0:0]         w_state_nx;
   logic [ADDR_W-1:0]  w_addr_nx;
   logic [BURST_W-1:0] w_remaining_nx;
   logic               w_mode_nx;
   logic [WL-1:0]      w_wordline_nx;
   logic [ADDR_W-1:0]  w_addr_inc;
   logic               w_accept;

   // A start is taken in IDLE, or on an unstalled final beat for a gapless hand-off.
   assign w_accept = start && ((r_state == S_IDLE) ||
                               ((r_remaining == '0) && !stall));

   assign w_addr_inc = r_mode
      ? ((r_cur_addr & ~BLK_MASK) | ((r_cur_addr + ADDR_W'(1)) & BLK_MASK))
      : (r_cur_addr + ADDR_W'(1));

   always_comb begin
      w_state_nx     = r_state;
      w_addr_nx      = r_cur_addr;
      w_remaining_nx = r_remaining;
      w_mode_nx      = r_mode;
      if (w_accept) begin
         w_state_nx     = S_BURST;
         w_addr_nx      = addr_in;
         w_remaining_nx = burst_len;
         w_mode_nx      = wrap_en;
      end else if ((r_state == S_BURST) && !stall) begin
         if (r_remaining != '0) begin
            w_addr_nx      = w_addr_inc;
            w_remaining_nx = r_remaining - BURST_W'(1);
         end else begin
            w_state_nx = S_IDLE;
            w_addr_nx  = '0;
         end
      end
   end

   // Decoding the next address keeps the wordline a clean flop output.
   assign w_wordline_nx = (w_state_nx == S_BURST) ? (WL'(1) << w_addr_nx) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cur_addr  <= '0;
         r_remaining <= '0;
         r_mode      <= 1'b0;
         r_wordline  <= '0;
      end else begin
         r_state     <= w_state_nx;
         r_cur_addr  <= w_addr_nx;
         r_remaining <= w_remaining_nx;
         r_mode      <= w_mode_nx;
         r_wordline  <= w_wordline_nx;
      end
   end

   assign wordline = r_wordline;
   assign wl_valid = (r_state == S_BURST);
   assign wl_last  = wl_valid && (r_remaining == '0);
   assign cur_addr = r_cur_addr;
   assign busy     = wl_valid;

endmodule
